// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART command receiver with start-glitch rejection, 3-sample
// majority vote, stop-bit check and a hold timeout that clears stale commands.
module uart_cmd_rx #(
   parameter int CLKS_PER_BIT = 28,
   parameter int HOLD_TIMEOUT = 322560
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rxd,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_stale
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] CNT_DEC  = CW'(CLKS_PER_BIT / 2 + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_MAX    = TW'(HOLD_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic            r_sync1;
   logic            r_sync2;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bitIdx;
   logic            r_smp0;
   logic            r_smp1;
   logic [7:0]      r_shift;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_frameErr;
   logic            r_stale;
   logic [TW-1:0]   r_timer;

   logic            w_majority;
   logic            w_decide;
   logic            w_bitEnd;
   logic            w_timing;
   logic            w_shiftEn;
   logic            w_commit;
   logic            w_frameErr;

   // The third sample is the live synchroniser output at the decision point.
   assign w_majority = (r_smp0 & r_smp1) | (r_smp0 & r_sync2) | (r_smp1 & r_sync2);
   assign w_decide   = (r_cnt == CNT_DEC);
   assign w_bitEnd   = (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_rxd;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (!r_sync2) w_nextState = S_START;
         S_START: begin
            if (w_decide && w_majority) begin
               w_nextState = S_IDLE;
            end else if (w_bitEnd) begin
               w_nextState = S_DATA;
            end
         end
         S_DATA:  if (w_bitEnd && r_bitIdx == 3'd7) w_nextState = S_STOP;
         S_STOP:  if (w_decide) w_nextState = w_majority ? S_IDLE : S_BREAK;
         S_BREAK: if (r_sync2) w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      w_timing   = 1'b0;
      w_shiftEn  = 1'b0;
      w_commit   = 1'b0;
      w_frameErr = 1'b0;
      case (r_state)
         S_START: w_timing = 1'b1;
         S_DATA: begin
            w_timing  = 1'b1;
            w_shiftEn = w_decide;
         end
         S_STOP: begin
            w_timing   = 1'b1;
            w_commit   = w_decide & w_majority;
            w_frameErr = w_decide & ~w_majority;
         end
         default: ;
      endcase
   end

   // Bit timer restarts whenever the receiver drops out of a frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_bitIdx <= 3'd0;
         r_smp0   <= 1'b0;
         r_smp1   <= 1'b0;
         r_shift  <= 8'h00;
      end else begin
         if (!w_timing || w_nextState == S_IDLE || w_nextState == S_BREAK || w_bitEnd) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state != S_DATA) begin
            r_bitIdx <= 3'd0;
         end else if (w_bitEnd) begin
            r_bitIdx <= r_bitIdx + 3'd1;
         end
         if (r_cnt == CNT_S0) r_smp0 <= r_sync2;
         if (r_cnt == CNT_S1) r_smp1 <= r_sync2;
         if (w_shiftEn) r_shift <= {w_majority, r_shift[7:1]};
      end
   end

   // A commit resets the hold timer and takes priority over its expiry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data     <= 8'h00;
         r_valid    <= 1'b0;
         r_frameErr <= 1'b0;
         r_stale    <= 1'b1;
         r_timer    <= '0;
      end else begin
         r_valid    <= w_commit;
         r_frameErr <= w_frameErr;
         if (w_commit) begin
            r_data  <= r_shift;
            r_stale <= 1'b0;
            r_timer <= '0;
         end else if (r_timer != T_MAX) begin
            r_timer <= r_timer + 1'b1;
            if (r_timer == T_MAX - 1'b1) begin
               r_data  <= 8'h00;
               r_stale <= 1'b1;
            end
         end
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frameErr;
   assign o_stale     = r_stale;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: a directed vector table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_uart_cmd_rx;

   localparam int C    = 28;
   localparam int HOLD = 1000;
   localparam int LAT  = 270;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_rxd;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_stale;

   uart_cmd_rx #(
      .CLKS_PER_BIT(C),
      .HOLD_TIMEOUT(HOLD)
   ) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_rxd      (i_rxd),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_frame_err(o_frame_err),
      .o_stale    (o_stale)
   );

   always #5 clk = ~clk;

   // Rising edges seen so far; read on falling edges only.
   int cycleCount = 0;
   always @(posedge clk) cycleCount <= cycleCount + 1;

   int checks = 0;
   int errors = 0;

   // Capture of output pulses, sampled on the falling edge.
   int         validCycles[$];
   logic [7:0] validData[$];
   int         errPulses    = 0;
   int         overlapCount = 0;

   always @(negedge clk) begin
      if (o_valid) begin
         validCycles.push_back(cycleCount);
         validData.push_back(o_data);
      end
      if (o_frame_err) errPulses++;
      if (o_valid && o_frame_err) overlapCount++;
   end

   // Frame-level reference model: last good byte and when it was committed.
   logic [7:0] mLastGood   = 8'h00;
   bit         mHasCommit  = 1'b0;
   int         mCommitCycle = 0;

   function automatic bit expStale(input int t);
      return !mHasCommit || (t - mCommitCycle >= HOLD);
   endfunction

   function automatic logic [7:0] expData(input int t);
      return expStale(t) ? 8'h00 : mLastGood;
   endfunction

   // Line level d cycles after the start edge; bad frames keep the stop bit low.
   function automatic logic frameLevel(input logic [7:0] b, input bit stopGood, input int d);
      int bitNo;
      bitNo = d / C;
      if (bitNo == 0) return 1'b0;
      if (bitNo <= 8) return b[bitNo-1];
      return stopGood;
   endfunction

   task automatic checkEq(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkRange(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic clearCapture();
      validCycles.delete();
      validData.delete();
      errPulses = 0;
   endtask

   task automatic idleCycles(input int n);
      i_rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] rstSnapData;
   logic       rstSnapValid;
   logic       rstSnapErr;
   logic       rstSnapStale;

   // Drives one frame cycle by cycle; optional one-cycle noise at a bit centre
   // and an optional one-cycle reset pulse at a given offset.
   task automatic applyStimulus(input logic [7:0] b, input bit stopGood, input int noiseBit,
                                input int rstAt, output int startEdge);
      int   total;
      logic lvl;
      total = stopGood ? 10 * C : 11 * C;
      startEdge = 0;
      for (int d = 0; d < total; d++) begin
         @(negedge clk);
         if (d == 0) startEdge = cycleCount + 1;
         lvl = frameLevel(b, stopGood, d);
         if (noiseBit >= 0 && d == noiseBit * C + C / 2 + 1) lvl = ~lvl;
         i_rxd = lvl;
         if (d == rstAt) begin
            i_rst = 1'b1;
         end else if (rstAt >= 0 && d == rstAt + 1) begin
            rstSnapData  = o_data;
            rstSnapValid = o_valid;
            rstSnapErr   = o_frame_err;
            rstSnapStale = o_stale;
            i_rst = 1'b0;
         end
      end
      if (!stopGood) begin
         @(negedge clk);
         i_rxd = 1'b1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] b, input bit expValid,
                              input bit expErr, input int startEdge);
      int t;
      if (expValid) begin
         mLastGood    = b;
         mHasCommit   = 1'b1;
         mCommitCycle = startEdge + LAT;
      end
      checkEq({tag, " valid pulses"}, validCycles.size(), expValid ? 1 : 0);
      checkEq({tag, " frame_err pulses"}, errPulses, expErr ? 1 : 0);
      if (expValid && validCycles.size() > 0) begin
         checkEq({tag, " valid data"}, validData[0], b);
         checkRange({tag, " latency"}, validCycles[0] - startEdge, LAT - 1, LAT + 1);
      end
      @(negedge clk);
      t = cycleCount;
      if (!mHasCommit || (t - (mCommitCycle + HOLD) > 2) || ((mCommitCycle + HOLD) - t > 2)) begin
         checkEq({tag, " o_stale"}, o_stale, expStale(t));
         checkEq({tag, " o_data"}, o_data, expData(t));
      end
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stopGood;
      int         noiseBit;
      bit         expValid;
      bit         expErr;
   } vec_t;

   vec_t       vecs[7];
   int         se;
   int         se2;
   int         vCyc;
   int         staleCycle;
   logic [7:0] heldData;
   logic [7:0] rb;
   bit         rGood;
   int         rNoise;

   initial begin
      vecs[0] = '{8'h77, 1'b0, -1, 1'b0, 1'b1};
      vecs[1] = '{8'h11, 1'b1, -1, 1'b1, 1'b0};
      vecs[2] = '{8'hC3, 1'b1,  3, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 1'b1,  0, 1'b1, 1'b0};
      vecs[4] = '{8'hFF, 1'b1,  8, 1'b1, 1'b0};
      vecs[5] = '{8'h96, 1'b0,  5, 1'b0, 1'b1};
      vecs[6] = '{8'hE7, 1'b1,  1, 1'b1, 1'b0};

      i_rst = 1'b1;
      i_rxd = 1'b1;
      repeat (3) @(negedge clk);
      i_rst = 1'b0;
      checkEq("reset o_data", o_data, 8'h00);
      checkEq("reset o_valid", o_valid, 1'b0);
      checkEq("reset o_frame_err", o_frame_err, 1'b0);
      checkEq("reset o_stale", o_stale, 1'b1);
      idleCycles(5);

      $display("[TB] single frame 0x5A");
      clearCapture();
      applyStimulus(8'h5A, 1'b1, -1, -1, se);
      checkOutput("frame 5A", 8'h5A, 1'b1, 1'b0, se);

      $display("[TB] hold timeout after 0x5A");
      vCyc = (validCycles.size() > 0) ? validCycles[0] : cycleCount;
      heldData = o_data;
      for (int i = 0; i < 2 * HOLD && !o_stale; i++) begin
         heldData = o_data;
         @(negedge clk);
      end
      staleCycle = cycleCount;
      checkEq("timeout o_stale", o_stale, 1'b1);
      checkEq("timeout delay", staleCycle - vCyc, HOLD);
      checkEq("data held before timeout", heldData, 8'h5A);
      checkEq("timeout o_data", o_data, 8'h00);
      clearCapture();
      idleCycles(300);
      checkEq("idle after timeout valid pulses", validCycles.size(), 0);
      checkEq("idle after timeout o_data", o_data, 8'h00);
      checkEq("idle after timeout o_stale", o_stale, 1'b1);

      $display("[TB] start-bit glitch");
      clearCapture();
      @(negedge clk);
      i_rxd = 1'b0;
      repeat (5) @(negedge clk);
      i_rxd = 1'b1;
      idleCycles(2 * C);
      checkEq("glitch valid pulses", validCycles.size(), 0);
      checkEq("glitch frame_err pulses", errPulses, 0);
      clearCapture();
      applyStimulus(8'h3C, 1'b1, -1, -1, se);
      checkOutput("frame 3C", 8'h3C, 1'b1, 1'b0, se);
      idleCycles(20);

      $display("[TB] vector table");
      foreach (vecs[i]) begin
         clearCapture();
         applyStimulus(vecs[i].data, vecs[i].stopGood, vecs[i].noiseBit, -1, se);
         checkOutput($sformatf("vec%0d", i), vecs[i].data, vecs[i].expValid, vecs[i].expErr, se);
         idleCycles(20);
      end

      $display("[TB] back-to-back frames");
      clearCapture();
      applyStimulus(8'h01, 1'b1, -1, -1, se);
      applyStimulus(8'h80, 1'b1, -1, -1, se2);
      idleCycles(5);
      checkEq("b2b valid pulses", validCycles.size(), 2);
      if (validCycles.size() >= 2) begin
         checkEq("b2b first data", validData[0], 8'h01);
         checkEq("b2b second data", validData[1], 8'h80);
         checkRange("b2b spacing", validCycles[1] - validCycles[0], 10 * C - 1, 10 * C + 1);
         checkRange("b2b first latency", validCycles[0] - se, LAT - 1, LAT + 1);
      end
      mLastGood = 8'h80;
      mHasCommit = 1'b1;
      mCommitCycle = se2 + LAT;
      checkEq("b2b o_data", o_data, expData(cycleCount));
      idleCycles(20);

      $display("[TB] reset during data bit 3");
      clearCapture();
      applyStimulus(8'hFF, 1'b1, -1, 4 * C + 10, se);
      mLastGood = 8'h00;
      mHasCommit = 1'b0;
      checkEq("mid-frame reset o_data", rstSnapData, 8'h00);
      checkEq("mid-frame reset o_valid", rstSnapValid, 1'b0);
      checkEq("mid-frame reset o_frame_err", rstSnapErr, 1'b0);
      checkEq("mid-frame reset o_stale", rstSnapStale, 1'b1);
      idleCycles(10);
      checkEq("aborted frame valid pulses", validCycles.size(), 0);
      checkEq("aborted frame frame_err pulses", errPulses, 0);
      clearCapture();
      applyStimulus(8'hA5, 1'b1, -1, -1, se);
      checkOutput("frame A5", 8'hA5, 1'b1, 1'b0, se);
      idleCycles(10);

      $display("[TB] randomized frames");
      for (int n = 0; n < 30; n++) begin
         rb     = 8'($urandom);
         rGood  = ($urandom_range(0, 3) != 0);
         rNoise = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8)) : -1;
         clearCapture();
         applyStimulus(rb, rGood, rNoise, -1, se);
         checkOutput($sformatf("rand%0d", n), rb, rGood, !rGood, se);
         idleCycles(int'($urandom_range(0, 40)));
      end

      checkEq("valid/frame_err overlap", overlapCount, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got %0d cycles, expected completion before 60000", cycleCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
